// File: rtl/ramspnc_arb_pkg.sv
// Shared constants for ramspnc_arb. RD_LAT is 2 when RAMSPNC_ARB_OUTREG_EN is defined, else 1.
package ramspnc_arb_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 6;

`ifdef RAMSPNC_ARB_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ramspnc_arb_ram.sv
// Single-port no-change RAM: a write leaves dout holding the last read value.
module ramspnc
  import ramspnc_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= din;
      else    dout_q      <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ramspnc_arb.sv
// Round-robin arbiter sharing one ramspnc between N requesters.
// Define RAMSPNC_ARB_OUTREG_EN to register the read response (latency 2).
module ramspnc_arb
  import ramspnc_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_din,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rot;
  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  int            ofs, sum;

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic          rd_v_q, rd_v_d;
  logic [IW-1:0] rd_idx_q;
  logic [N-1:0]  rsp_valid_c;
  logic [DW-1:0] rsp_data_c;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot       = N'({req_valid, req_valid} >> ptr_q);
    gnt_found = 1'b0;
    ofs       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_found = 1'b1;
        ofs       = k;
      end
    end
    sum = int'(ptr_q) + ofs;
    if (sum >= N) sum = sum - N;
    gnt_idx = IW'(sum);
  end

  always_comb begin
    req_ready = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == IW'(i)) begin
        req_ready[i] = gnt_found;
        ram_we       = req_we[i];
        ram_addr     = req_addr[i*AW +: AW];
        ram_din      = req_din[i*DW +: DW];
      end
    end
    ram_en = gnt_found;
    rd_v_d = gnt_found & ~ram_we;
    ptr_d  = ptr_q;
    if (gnt_found) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rd_v_q   <= rd_v_d;
      rd_idx_q <= gnt_idx;
    end
  end

  ramspnc #(.DW(DW), .AW(AW)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // RAM output is undefined until first read, so gate it with the response strobe.
  always_comb begin
    rsp_valid_c = '0;
    rsp_data_c  = '0;
    if (rd_v_q) begin
      rsp_valid_c[rd_idx_q] = 1'b1;
      rsp_data_c            = ram_dout;
    end
  end

`ifdef RAMSPNC_ARB_OUTREG_EN
  logic [N-1:0]  out_v_q;
  logic [DW-1:0] out_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= '0;
      out_d_q <= '0;
    end else begin
      out_v_q <= rsp_valid_c;
      out_d_q <= rsp_data_c;
    end
  end

  assign rsp_valid = out_v_q;
  assign rsp_data  = out_d_q;
  assign busy      = rd_v_q | (|out_v_q);
`else
  assign rsp_valid = rsp_valid_c;
  assign rsp_data  = rsp_data_c;
  assign busy      = rd_v_q;
`endif

endmodule

// File: tb/tb_ramspnc_arb.sv
// Self-checking bench for ramspnc_arb against a queue-based transaction model.
module tb_ramspnc_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 6;
`ifdef RAMSPNC_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int HN = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  ramspnc_arb #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          pend[$];
  logic [DW-1:0] mem [1<<AW];
  int            m_ptr, cyc, checks, errors;
  int            hist_g  [HN];
  logic [N-1:0]  hist_rv [HN];
  logic [DW-1:0] hist_rd [HN];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    int g, j;
    g = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (g < 0 && ((req_valid >> j) & 1) != 0) g = j;
    end
    return g;
  endfunction

  // One clock of traffic: predict, compare at negedge, then advance the model.
  task automatic step();
    int            g;
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    logic          eb;
    logic [AW-1:0] a;
    g  = model_grant();
    ev = '0;
    ed = '0;
    eb = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = N'(1) << pend[0].idx;
      ed = pend[0].data;
    end
    foreach (pend[i]) if (pend[i].due - LAT < cyc && cyc <= pend[i].due) eb = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data", rsp_data, ed);
    chk("busy", busy, eb);
    chk("ptr", dut.ptr_q, m_ptr);
    chk("ram_en", dut.ram_en, g >= 0);
    if (cyc < HN) begin
      hist_g[cyc]  = g;
      hist_rv[cyc] = rsp_valid;
      hist_rd[cyc] = rsp_data;
    end
    @(posedge clk);
    if (g >= 0) begin
      a = AW'(req_addr >> (g * AW));
      if (((req_we >> g) & 1) != 0) mem[a] = DW'(req_din >> (g * DW));
      else pend.push_back('{cyc + LAT, g, mem[a]});
      m_ptr = (g + 1) % N;
    end
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    #1;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    pend.delete();
    m_ptr = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ptr", dut.ptr_q, 0);
      @(posedge clk);
      cyc++;
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic one(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = N'(1) << i;
    req_we    = we ? (N'(1) << i) : '0;
    req_addr  = (N*AW)'(a) << (i * AW);
    req_din   = (N*DW)'(d) << (i * DW);
    step();
  endtask

  task automatic idle();
    req_valid = '0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            t, t2;
    logic [DW-1:0] val;
    checks = 0; errors = 0; cyc = 0; m_ptr = 0;
    req_valid = '0; req_we = '0; req_addr = '0; req_din = '0;
    do_reset(3);

    // Preload every address so the model never reads unknown contents.
    for (int k = 0; k < (1 << AW); k++) begin
      val = $urandom;
      if (k < 4)  val = 32'h10 + DW'(k);
      if (k == 7) val = 32'hA5;
      one(k % N, 1'b1, AW'(k), val);
    end

    // Write then read back through requester 1.
    one(1, 1'b1, 6'd5, 32'hDEADBEEF);
    t = cyc;
    one(1, 1'b0, 6'd5, 32'h0);
    repeat (LAT + 1) idle();
    chk("t1_early", hist_rv[t + LAT - 1], 4'b0000);
    chk("t1_rsp_valid", hist_rv[t + LAT], 4'b0010);
    chk("t1_rsp_data", hist_rd[t + LAT], 32'hDEADBEEF);

    // All four requesters hold reads of 0..3, starting with ptr at 0.
    one(3, 1'b0, 6'd7, 32'h0);
    req_valid = 4'hF;
    req_we    = '0;
    req_addr  = {6'd3, 6'd2, 6'd1, 6'd0};
    t = cyc;
    repeat (4) step();
    chk("t2_ptr_wrap", dut.ptr_q, 0);
    repeat (LAT + 1) idle();
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", hist_g[t + k], k);
      chk("t2_rsp_valid", hist_rv[t + k + LAT], 1 << k);
      chk("t2_rsp_data", hist_rd[t + k + LAT], 32'h10 + k);
    end

    // Requesters 0 and 2 contend continuously.
    t = cyc;
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b0101;
      req_we    = '0;
      req_addr  = (N*AW)'({$urandom, $urandom});
      step();
    end
    for (int k = 0; k < 8; k++) chk("t3_alternate", hist_g[t + k], (k % 2) * 2);
    repeat (LAT) idle();

    // Read of address 7 immediately followed by another requester's write.
    t = cyc;
    one(3, 1'b0, 6'd7, 32'h0);
    one(0, 1'b1, 6'd7, 32'h5A);
    repeat (LAT) idle();
    t2 = cyc;
    one(1, 1'b0, 6'd7, 32'h0);
    repeat (LAT + 1) idle();
    chk("t4_old_valid", hist_rv[t + LAT], 4'b1000);
    chk("t4_old_data", hist_rd[t + LAT], 32'hA5);
    chk("t4_new_data", hist_rd[t2 + LAT], 32'h5A);

    // Reset one cycle after a read grant discards the response and the pointer.
    one(2, 1'b0, 6'd9, 32'h0);
    do_reset(2);
    req_valid = 4'b1010;
    req_we    = '0;
    t = cyc;
    step();
    chk("t5_first_grant", hist_g[t], 1);
    repeat (LAT + 1) idle();

    // Quiet period: pointer holds.
    repeat (10) idle();
    chk("t6_ptr_hold", dut.ptr_q, 2);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        req_valid = N'($urandom);
        req_we    = N'($urandom);
        req_addr  = (N*AW)'({$urandom, $urandom});
        req_din   = {$urandom, $urandom, $urandom, $urandom};
        step();
      end
    end
    repeat (LAT + 1) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramspnc_arb.md
# ramspnc_arb

Round-robin arbiter that shares one single-port, no-change RAM (`ramspnc`, DW×2^AW) between N requesters. It accepts one read or write per cycle from a valid/ready request port, drives the RAM enable/write/address/data, and routes read data back to the issuing requester with a one-hot response strobe. It sits between client engines and the memory macro. All memory access in the subsystem goes through this block.

## Interface
- N, default 4: number of requesters, ≥2
- DW, default 32: data width
- AW, default 6: address width; depth is 2^AW
- IW, derived as max(1, $clog2(N)): requester index width, not overridable

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N  request present, one bit per requester
- req_we  in  N  1 = write, 0 = read
- req_addr  in  N*AW  address; requester i uses bits [i*AW +: AW]
- req_din  in  N*DW  write data; requester i uses bits [i*DW +: DW]
- req_ready  out  N  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  N  one-hot read-response strobe, one cycle
- rsp_data  out  DW  read data, shared by all requesters; qualified by rsp_valid
- busy  out  1  a read response is in flight

## Operation
- Arbitration is combinational round-robin over req_valid. The search starts at pointer ptr (IW bits) and wraps at N-1 to 0.
- req_ready[i] is 1 only for the single selected requester, and only when req_valid[i]=1. req_ready depends combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- At most one grant per cycle. A grant always completes; there are no wait states.
- After a grant to requester g, ptr ← (g+1) mod N. With no request, ptr holds.
- RAM drive:
  - en = |grant
  - we = req_we[g]
  - addr = req_addr[g]
  - din = req_din[g]
- Write grant: the memory is updated at the clock edge. No response is produced. The RAM output holds its previous read value (no-change behaviour).
- Read grant: the index g is registered in the response pipeline. At read latency, rsp_valid[g]=1 and rsp_data holds mem[addr].
- rsp_data is forced to 0 whenever no rsp_valid bit is set, so it is never X after reset.
- busy = 1 while any read response stage is occupied.
- Requester requests are independent. A requester may issue back-to-back requests when granted on consecutive cycles, including when it is the only one requesting.
- Same-address write followed by a read on the next grant returns the new data, because the accesses are serialized.

## Timing
- Reset (async assert, sync deassert by the system):
  - ptr = 0
  - rsp_valid = 0
  - rsp_data = 0
  - busy = 0
  - req_ready follows req_valid combinationally, with ptr = 0 giving requester 0 priority.
- Read latency without OUTREG: grant in cycle T gives rsp_valid in cycle T+1.
- Read latency with OUTREG: grant in cycle T gives rsp_valid in cycle T+2.
- Throughput is one access per cycle. Reads are fully pipelined, so N back-to-back reads produce N consecutive responses in grant order.
- Reset asserted mid-operation: in-flight responses are discarded (no rsp_valid after reset) and ptr returns to 0. Memory contents are not cleared.
- Simultaneous write by one requester and pending response to another: both occur. The response carries the earlier read value, which is correct because the RAM holds dout on a write.

## Configuration
- RAMSPNC_ARB_OUTREG_EN defined:
  - adds a reset-to-0 register on rsp_data and rsp_valid
  - read latency becomes 2
  - busy covers both stages
- RAMSPNC_ARB_OUTREG_EN undefined:
  - rsp_data is taken from the RAM output through the zero-gate
  - read latency is 1

## Structure
- Shared package ramspnc_arb_pkg holds:
  - index-width helper function
  - default DW/AW/N localparams
  - read-latency constant (1 or 2 per macro)
- Sub-module: a ramspnc instance (DW, AW passed through) for storage.
- Arbitration, ptr and response pipeline are local logic; no separate arbiter module.

## Test plan
- Reset, then requester 1 writes 0xDEADBEEF to address 5, then reads address 5 → rsp_valid=4'b0010 one cycle later (two with OUTREG), rsp_data=0xDEADBEEF; rsp_data=0 on all other cycles.
- All four requesters hold reads to addresses 0..3 (preloaded 0x10..0x13) → grants 0,1,2,3 in consecutive cycles; responses arrive in the same order with the matching data; ptr wraps to 0.
- Requesters 0 and 2 continuously valid → grants alternate 0,2,0,2, with no starvation and no double grant.
- Requester 3 reads address 7 (value 0xA5) immediately followed by requester 0 writing 0x5A to address 7 → requester 3 receives 0xA5; a later read returns 0x5A.
- Assert rst one cycle after a read grant → no rsp_valid after reset, busy=0, ptr=0, and the next grant goes to the lowest-index valid requester.
- No requests for 10 cycles → en=0, req_ready=0, ptr unchanged, rsp_valid=0.
